// File: rtl/kbd_mmio_port_pkg.sv
// Shared constants, receiver state type and frame check for the PS/2 keyboard MMIO port.
package kbd_mmio_port_pkg;

    localparam logic        ADDR_DATA      = 1'b0;
    localparam logic        ADDR_STATUS    = 1'b1;

    localparam int unsigned STAT_COUNT_LSB = 0;
    localparam int unsigned STAT_COUNT_W   = 5;
    localparam int unsigned STAT_OVF_BIT   = 8;
    localparam int unsigned STAT_ERR_LSB   = 16;
    localparam int unsigned DATA_VALID_BIT = 8;

    localparam int unsigned FRAME_LEN      = 11;
    // Start, parity and stop bits surround the payload.
    localparam int unsigned DATA_BITS      = FRAME_LEN - 3;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity,
        StStop
    } rx_state_e;

    function automatic logic frame_ok(input logic [7:0] data, input logic par, input logic stop);
        return stop & (^{data, par});
    endfunction

endpackage

// File: rtl/kbd_mmio_port_ps2_rx.sv
// PS/2 frame receiver: input synchronizers, clock glitch filter, frame FSM and stall timeout.
module kbd_mmio_port_ps2_rx
    import kbd_mmio_port_pkg::*;
#(
    parameter int unsigned FILT_LEN    = 8,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic       clk_i,
    input  logic       rst_n,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_o,
    output logic       frame_err_o
);

    localparam int unsigned FiltW = $clog2(FILT_LEN + 1);
    localparam int unsigned TmoW  = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned BitW  = $clog2(DATA_BITS);

    logic [1:0]      clk_sync_q;
    logic [1:0]      data_sync_q;
    logic            filt_q;
    logic [FiltW-1:0] filt_cnt_q;
    logic            fall;
    logic            samp;

    rx_state_e       state_q;
    logic [BitW-1:0] bit_cnt_q;
    logic [7:0]      shift_q;
    logic            par_q;
    logic [TmoW-1:0] tmo_q;
    logic            byte_valid_q;
    logic            frame_err_q;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            filt_q      <= 1'b1;
            filt_cnt_q  <= '0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
            data_sync_q <= {data_sync_q[0], ps2_data_i};
            if (clk_sync_q[1] == filt_q) begin
                filt_cnt_q <= '0;
            end else if (filt_cnt_q == FiltW'(FILT_LEN - 1)) begin
                filt_q     <= clk_sync_q[1];
                filt_cnt_q <= '0;
            end else begin
                filt_cnt_q <= filt_cnt_q + 1'b1;
            end
        end
    end

    // Fall is flagged in the cycle the filtered clock is about to drop, so data is sampled then.
    assign fall = filt_q & ~clk_sync_q[1] & (filt_cnt_q == FiltW'(FILT_LEN - 1));
    assign samp = data_sync_q[1];

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            tmo_q        <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            if (state_q != StIdle && !fall && tmo_q == TmoW'(TIMEOUT_CYC - 1)) begin
                state_q     <= StIdle;
                tmo_q       <= '0;
                frame_err_q <= 1'b1;
            end else if (fall) begin
                tmo_q <= '0;
                unique case (state_q)
                    StIdle: begin
                        if (!samp) begin
                            state_q   <= StData;
                            bit_cnt_q <= '0;
                        end
                    end
                    StData: begin
                        shift_q   <= {samp, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == BitW'(DATA_BITS - 1)) begin
                            state_q <= StParity;
                        end
                    end
                    StParity: begin
                        par_q   <= samp;
                        state_q <= StStop;
                    end
                    StStop: begin
                        state_q <= StIdle;
                        if (frame_ok(shift_q, par_q, samp)) begin
                            byte_valid_q <= 1'b1;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end else if (state_q != StIdle) begin
                tmo_q <= tmo_q + 1'b1;
            end else begin
                tmo_q <= '0;
            end
        end
    end

    assign byte_valid_o = byte_valid_q;
    assign byte_o       = shift_q;
    assign frame_err_o  = frame_err_q;

endmodule

// File: rtl/kbd_mmio_port.sv
// PS/2 keyboard MMIO port: receiver, scan-code FIFO, error counter and one-cycle-latency read port.
module kbd_mmio_port
    import kbd_mmio_port_pkg::*;
#(
    parameter int unsigned FIFO_AW     = 4,
    parameter int unsigned FILT_LEN    = 8,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        ps2_clk_i,
    input  logic        ps2_data_i,
    input  logic        rd_en_i,
    input  logic        rd_addr_i,
    output logic [31:0] rd_data_o,
    output logic        rd_stall_o,
    output logic        kbd_irq_o
);

    localparam int unsigned Depth = 1 << FIFO_AW;
    localparam int unsigned CntW  = FIFO_AW + 1;

    logic             rx_byte_valid;
    logic [7:0]       rx_byte;
    logic             rx_frame_err;

    logic [7:0]       fifo_q [Depth];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [7:0]       err_q, err_d;
    logic [31:0]      rd_data_q, rd_data_d;
    logic             rd_en_q;
    logic             irq_q;

    logic             empty, full, start, push, pop;
    logic [31:0]      rd_word;

    kbd_mmio_port_ps2_rx #(
        .FILT_LEN    (FILT_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx (
        .clk_i        (clk_i),
        .rst_n        (rst_n),
        .ps2_clk_i    (ps2_clk_i),
        .ps2_data_i   (ps2_data_i),
        .byte_valid_o (rx_byte_valid),
        .byte_o       (rx_byte),
        .frame_err_o  (rx_frame_err)
    );

    assign empty = (count_q == '0);
    assign full  = (count_q == CntW'(Depth));
    assign start = rd_en_i & ~rd_en_q;
    assign pop   = start & (rd_addr_i == ADDR_DATA) & ~empty;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign push  = rx_byte_valid & (~full | pop);

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end

        ovf_d = ovf_q;
        if (rx_byte_valid && full && !pop) begin
            ovf_d = 1'b1;
        end else if (start && rd_addr_i == ADDR_STATUS) begin
            ovf_d = 1'b0;
        end

        err_d = err_q;
        if (rx_frame_err && err_q != 8'hff) begin
            err_d = err_q + 1'b1;
        end

        rd_word = '0;
        unique case (rd_addr_i)
            ADDR_DATA: begin
                if (!empty) begin
                    rd_word[7:0]           = fifo_q[rd_ptr_q];
                    rd_word[DATA_VALID_BIT] = 1'b1;
                end
            end
            ADDR_STATUS: begin
                rd_word[STAT_COUNT_LSB +: STAT_COUNT_W] = STAT_COUNT_W'(count_q);
                rd_word[STAT_OVF_BIT]                   = ovf_q;
                rd_word[STAT_ERR_LSB +: 8]              = err_q;
            end
            default: rd_word = '0;
        endcase

        rd_data_d = start ? rd_word : rd_data_q;
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= rx_byte;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            err_q     <= '0;
            rd_data_q <= '0;
            rd_en_q   <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            err_q     <= err_d;
            rd_data_q <= rd_data_d;
            rd_en_q   <= rd_en_i;
            irq_q     <= (count_d != '0);
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_stall_o = start;
    assign kbd_irq_o  = irq_q;

endmodule

// File: tb/tb_kbd_mmio_port.sv
// Directed self-checking bench for kbd_mmio_port: PS/2 frames in, MMIO reads out.
module tb_kbd_mmio_port;

    localparam int HALF = 8;

    logic        clk_i = 1'b0;
    logic        rst_n = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic        rd_en = 1'b0;
    logic        rd_addr = 1'b0;
    logic [31:0] rd_data;
    logic        rd_stall;
    logic        kbd_irq;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    kbd_mmio_port #(
        .FIFO_AW     (4),
        .FILT_LEN    (2),
        .TIMEOUT_CYC (64)
    ) u_dut (
        .clk_i      (clk_i),
        .rst_n      (rst_n),
        .ps2_clk_i  (ps2_clk),
        .ps2_data_i (ps2_data),
        .rd_en_i    (rd_en),
        .rd_addr_i  (rd_addr),
        .rd_data_o  (rd_data),
        .rd_stall_o (rd_stall),
        .kbd_irq_o  (kbd_irq)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; rd_en = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_i);
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            repeat (HALF) @(negedge clk_i);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk_i);
            ps2_clk = 1'b1;
        end
        repeat (HALF) @(negedge clk_i);
        ps2_data = 1'b1;
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic bad_par);
        return {1'b1, (~^b) ^ bad_par, b, 1'b0};
    endfunction

    task automatic send_frame(input logic [7:0] b, input logic bad_par);
        send_bits(mk_frame(b, bad_par), 11);
        repeat (4) @(negedge clk_i);
    endtask

    // Holds rd_en for 'hold' cycles; reports first-cycle stall and total stall cycles.
    task automatic mmio_read(input logic addr, input int hold, output logic [31:0] data,
                             output logic first_stall, output int stalls);
        @(negedge clk_i);
        rd_en = 1'b1; rd_addr = addr; stalls = 0; first_stall = 1'b0;
        for (int i = 0; i < hold; i++) begin
            #1;
            if (i == 0) first_stall = rd_stall;
            if (rd_stall) stalls++;
            @(negedge clk_i);
        end
        data = rd_data;
        rd_en = 1'b0;
        @(negedge clk_i);
    endtask

    logic [31:0] d;
    logic        fs;
    int          ns;
    int          wait_n;

    initial begin
        // Reset state
        #1;
        check_eq("rst_rd_data", rd_data, 32'h0);
        check_eq("rst_stall", {31'b0, rd_stall}, 32'h0);
        check_eq("rst_irq", {31'b0, kbd_irq}, 32'h0);
        do_reset();

        // Good frame 0x1C
        send_frame(8'h1c, 1'b0);
        check_eq("good_irq", {31'b0, kbd_irq}, 32'h1);
        mmio_read(1'b0, 2, d, fs, ns);
        check_eq("good_data", d, 32'h0000_011c);
        check_eq("good_stall1", {31'b0, fs}, 32'h1);
        check_eq("good_nstall", ns, 1);
        check_eq("good_irq_after", {31'b0, kbd_irq}, 32'h0);

        // Bad parity
        send_frame(8'h1c, 1'b1);
        check_eq("badpar_irq", {31'b0, kbd_irq}, 32'h0);
        mmio_read(1'b1, 2, d, fs, ns);
        check_eq("badpar_status", d, 32'h0001_0000);

        // Empty DATA read held 5 cycles
        mmio_read(1'b0, 5, d, fs, ns);
        check_eq("empty_stall1", {31'b0, fs}, 32'h1);
        check_eq("empty_nstall", ns, 1);
        check_eq("empty_data", d, 32'h0);
        mmio_read(1'b1, 2, d, fs, ns);
        check_eq("empty_status", d, 32'h0001_0000);

        // Overflow: 17 frames, no reads
        do_reset();
        for (int i = 0; i <= 16; i++) send_frame(8'(i), 1'b0);
        mmio_read(1'b1, 2, d, fs, ns);
        check_eq("ovf_status1", d, 32'h0000_0110);
        mmio_read(1'b1, 2, d, fs, ns);
        check_eq("ovf_status2", d, 32'h0000_0010);
        for (int i = 0; i < 16; i++) begin
            mmio_read(1'b0, 2, d, fs, ns);
            check_eq($sformatf("ovf_data%0d", i), d, 32'h100 | 32'(i));
        end
        check_eq("ovf_irq_drained", {31'b0, kbd_irq}, 32'h0);

        // Timeout after 4 data bits, then good 0x5A
        do_reset();
        send_bits(mk_frame(8'h3c, 1'b0), 5);
        repeat (100) @(negedge clk_i);
        send_frame(8'h5a, 1'b0);
        mmio_read(1'b1, 2, d, fs, ns);
        check_eq("tmo_status", d, 32'h0001_0001);
        mmio_read(1'b0, 2, d, fs, ns);
        check_eq("tmo_data", d, 32'h0000_015a);

        // Push and pop in the same cycle while full
        do_reset();
        for (int i = 0; i < 16; i++) send_frame(8'h40 + 8'(i), 1'b0);
        fork
            send_frame(8'h77, 1'b0);
            begin
                wait_n = 0;
                @(posedge clk_i); #1;
                while (!u_dut.rx_byte_valid && wait_n < 400) begin
                    @(posedge clk_i); #1;
                    wait_n++;
                end
                if (wait_n >= 400) begin
                    check_eq("pp_push_seen", 32'h0, 32'h1);
                end else begin
                    rd_en = 1'b1; rd_addr = 1'b0;
                    #1;
                    check_eq("pp_stall", {31'b0, rd_stall}, 32'h1);
                    @(posedge clk_i); #1;
                    check_eq("pp_data", rd_data, 32'h0000_0140);
                    rd_en = 1'b0;
                end
            end
        join
        mmio_read(1'b1, 2, d, fs, ns);
        check_eq("pp_status", d, 32'h0000_0010);
        for (int i = 1; i < 16; i++) begin
            mmio_read(1'b0, 2, d, fs, ns);
            check_eq($sformatf("pp_data%0d", i), d, 32'h140 | 32'(i));
        end
        mmio_read(1'b0, 2, d, fs, ns);
        check_eq("pp_last", d, 32'h0000_0177);

        // Reset mid-frame with 3 queued and overflow set
        do_reset();
        for (int i = 0; i <= 16; i++) send_frame(8'h60 + 8'(i), 1'b0);
        for (int i = 0; i < 13; i++) mmio_read(1'b0, 2, d, fs, ns);
        check_eq("pre_rst_data", d, 32'h0000_016c);
        send_bits(mk_frame(8'h55, 1'b0), 4);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_data", rd_data, 32'h0);
        check_eq("mid_rst_irq", {31'b0, kbd_irq}, 32'h0);
        repeat (2) @(negedge clk_i);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_i);
        mmio_read(1'b1, 2, d, fs, ns);
        check_eq("post_rst_status", d, 32'h0);
        send_frame(8'h33, 1'b0);
        check_eq("post_rst_irq", {31'b0, kbd_irq}, 32'h1);
        mmio_read(1'b0, 2, d, fs, ns);
        check_eq("post_rst_data", d, 32'h0000_0133);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
